// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: helpers shared by the round-robin arbiter and its response router.
//   idx_w()     - encoded index width for N clients (at least 1 bit)
//   is_onehot() - exactly one bit set (all-zero is not one-hot)
//   onehot2bin()- binary index of the set bit of a one-hot vector
// Vectors are passed zero-extended to MAX_REQ bits; callers truncate the result
// to their own index width.
package rr_arb_pkg;

    localparam int unsigned MAX_REQ   = 32;
    localparam int unsigned MAX_IDX_W = 5;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic is_onehot(input logic [MAX_REQ-1:0] v);
        logic [MAX_REQ-1:0] one;
        one = {{(MAX_REQ-1){1'b0}}, 1'b1};
        return (v != '0) && ((v & (v - one)) == '0);
    endfunction

    function automatic logic [MAX_IDX_W-1:0] onehot2bin(input logic [MAX_REQ-1:0] v);
        logic [MAX_IDX_W-1:0] b;
        b = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (v[i]) begin
                b = b | i[MAX_IDX_W-1:0];
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_rsp_router_if.sv
// rr_rsp_router_if: issue, resource-response and client-response signals of the
// response router.
//   slave  - router side (consumes issue/rsp, drives client responses)
//   master - environment side (arbiter, resource and clients)
interface rr_rsp_router_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32
);
    logic               issue_vld;
    logic [NUM_REQ-1:0] issue_gnt;
    logic               issue_stall;
    logic               rsp_vld;
    logic [DATA_W-1:0]  rsp_data;
    logic               rsp_rdy;
    logic [NUM_REQ-1:0] cli_rsp_vld;
    logic [DATA_W-1:0]  cli_rsp_data;
    logic [NUM_REQ-1:0] cli_rsp_rdy;

    modport slave (
        input  issue_vld, issue_gnt, rsp_vld, rsp_data, cli_rsp_rdy,
        output issue_stall, rsp_rdy, cli_rsp_vld, cli_rsp_data
    );

    modport master (
        output issue_vld, issue_gnt, rsp_vld, rsp_data, cli_rsp_rdy,
        input  issue_stall, rsp_rdy, cli_rsp_vld, cli_rsp_data
    );
endinterface

// File: rtl/rr_idx_fifo.sv
// rr_idx_fifo: DEPTH x WIDTH synchronous FIFO holding encoded client indices.
//   clk, rstn      - clock, asynchronous active-low reset
//   push, din      - write request/data (ignored while full, even with a pop)
//   pop, dout      - read request (ignored while empty) / head entry
//   count          - occupancy 0..DEPTH
//   full, empty    - decoded from count
module rr_idx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push_en, pop_en;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign count   = cnt_q;
    assign dout    = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/rr_rsp_router.sv
// rr_rsp_router: steers in-order resource responses back to the client that was
// granted, using an in-order FIFO of encoded grant indices.
//   clk, rstn    - clock, asynchronous active-low reset
//   bus (slave)  - issue_vld/issue_gnt/issue_stall from/to the arbiter,
//                  rsp_vld/rsp_data/rsp_rdy from/to the resource,
//                  cli_rsp_vld/cli_rsp_data/cli_rsp_rdy to/from the clients
//   outstanding  - tag FIFO occupancy
//   err_unexp    - sticky: response arrived with nothing outstanding (dropped)
//   err_onehot   - sticky: issue_vld with a non-one-hot grant
// Build option RR_RSP_ROUTER_SKID_EN: registers the client outputs through a
// 2-entry skid buffer (1-cycle latency, rsp_rdy independent of cli_rsp_rdy).
module rr_rsp_router
    import rr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    rr_rsp_router_if.slave         bus,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   err_unexp,
    output logic                   err_onehot
);
    localparam int unsigned IDX_W = idx_w(NUM_REQ);

    logic [MAX_REQ-1:0] gnt_ext;
    logic               gnt_ok;
    logic [IDX_W-1:0]   issue_idx;
    logic [IDX_W-1:0]   head;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic               err_unexp_q, err_onehot_q;

    always_comb begin
        gnt_ext                = '0;
        gnt_ext[NUM_REQ-1:0]   = bus.issue_gnt;
        gnt_ok                 = is_onehot(gnt_ext);
        issue_idx              = IDX_W'(onehot2bin(gnt_ext));
    end

    rr_idx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IDX_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (bus.issue_vld & gnt_ok),
        .din   (issue_idx),
        .pop   (fifo_pop),
        .dout  (head),
        .count (outstanding),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.issue_stall = fifo_full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_unexp_q  <= 1'b0;
            err_onehot_q <= 1'b0;
        end else begin
            // With the FIFO empty rsp_rdy is forced high, so the beat is dropped.
            if (bus.rsp_vld && fifo_empty) begin
                err_unexp_q <= 1'b1;
            end
            if (bus.issue_vld && !gnt_ok) begin
                err_onehot_q <= 1'b1;
            end
        end
    end

    assign err_unexp  = err_unexp_q;
    assign err_onehot = err_onehot_q;

`ifdef RR_RSP_ROUTER_SKID_EN
    // Entry 0 is the one presented to the clients; entry 1 is the overflow slot.
    logic [1:0]        skid_cnt_q, skid_cnt_d;
    logic [IDX_W-1:0]  s0_idx_q, s0_idx_d, s1_idx_q, s1_idx_d;
    logic [DATA_W-1:0] s0_data_q, s0_data_d, s1_data_q, s1_data_d;
    logic              skid_acc, skid_drn;

    always_comb begin
        bus.rsp_rdy  = fifo_empty | (skid_cnt_q != 2'd2);
        skid_acc     = bus.rsp_vld & ~fifo_empty & (skid_cnt_q != 2'd2);
        skid_drn     = (skid_cnt_q != 2'd0) & bus.cli_rsp_rdy[s0_idx_q];
        fifo_pop     = skid_acc;

        bus.cli_rsp_vld = '0;
        if (skid_cnt_q != 2'd0) begin
            bus.cli_rsp_vld[s0_idx_q] = 1'b1;
        end
        bus.cli_rsp_data = s0_data_q;

        skid_cnt_d = skid_cnt_q;
        s0_idx_d   = s0_idx_q;
        s0_data_d  = s0_data_q;
        s1_idx_d   = s1_idx_q;
        s1_data_d  = s1_data_q;
        case ({skid_acc, skid_drn})
            2'b10: begin
                if (skid_cnt_q == 2'd0) begin
                    s0_idx_d  = head;
                    s0_data_d = bus.rsp_data;
                end else begin
                    s1_idx_d  = head;
                    s1_data_d = bus.rsp_data;
                end
                skid_cnt_d = skid_cnt_q + 2'd1;
            end
            2'b01: begin
                s0_idx_d   = s1_idx_q;
                s0_data_d  = s1_data_q;
                skid_cnt_d = skid_cnt_q - 2'd1;
            end
            2'b11: begin
                // Accept only happens below 2 entries, so here the count is 1.
                s0_idx_d  = head;
                s0_data_d = bus.rsp_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            skid_cnt_q <= 2'd0;
            s0_idx_q   <= '0;
            s0_data_q  <= '0;
            s1_idx_q   <= '0;
            s1_data_q  <= '0;
        end else begin
            skid_cnt_q <= skid_cnt_d;
            s0_idx_q   <= s0_idx_d;
            s0_data_q  <= s0_data_d;
            s1_idx_q   <= s1_idx_d;
            s1_data_q  <= s1_data_d;
        end
    end
`else
    always_comb begin
        bus.cli_rsp_vld  = '0;
        bus.cli_rsp_data = bus.rsp_data;
        bus.rsp_rdy      = 1'b1;
        fifo_pop         = 1'b0;
        if (!fifo_empty) begin
            bus.rsp_rdy           = bus.cli_rsp_rdy[head];
            bus.cli_rsp_vld[head] = bus.rsp_vld;
            fifo_pop              = bus.rsp_vld & bus.cli_rsp_rdy[head];
        end
    end
`endif

endmodule

// File: tb/tb_rr_rsp_router.sv
// tb_rr_rsp_router: table-driven vectors plus hand-written corner sequences for
// rr_rsp_router; client-side handshakes are checked against a scoreboard queue.
module tb_rr_rsp_router;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned DATA_W  = 32;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] outstanding;
    logic       err_unexp, err_onehot;

    always #5 clk = ~clk;

    rr_rsp_router_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    rr_rsp_router #(
        .NUM_REQ (NUM_REQ),
        .DEPTH   (DEPTH),
        .DATA_W  (DATA_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .outstanding (outstanding),
        .err_unexp   (err_unexp),
        .err_onehot  (err_onehot)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          client;
        logic [31:0] data;
    } exp_t;
    exp_t expq[$];

    typedef struct {
        logic        iv;
        logic [3:0]  gnt;
        logic        rv;
        logic [31:0] data;
        int          exp_cli;   // client that must receive this beat, -1 if none
        logic [3:0]  out;
        logic        stall;
        logic        eoh;
        logic        eux;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every completed client handshake must match the queue head.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.cli_rsp_vld[i] && bus.cli_rsp_rdy[i]) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: client %0d data %0h with nothing expected",
                                 i, bus.cli_rsp_data);
                    end else begin
                        exp_t e;
                        e = expq.pop_front();
                        chk("sb_client", i, e.client);
                        chk("sb_data", bus.cli_rsp_data, e.data);
                    end
                end
            end
        end
    end

    task automatic idle();
        bus.issue_vld   = 1'b0;
        bus.issue_gnt   = '0;
        bus.rsp_vld     = 1'b0;
        bus.rsp_data    = '0;
        bus.cli_rsp_rdy = '1;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
        expq.delete();
    endtask

    task automatic issue(input logic [3:0] gnt);
        bus.issue_vld = 1'b1;
        bus.issue_gnt = gnt;
        step();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   cl_seq[7];

        vecs[0] = '{1'b1, 4'b0001, 1'b0, 32'h0,    -1, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 4'b0100, 1'b0, 32'h0,    -1, 4'd2, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 4'b0010, 1'b0, 32'h0,    -1, 4'd3, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 4'b0000, 1'b1, 32'hA1,    0, 4'd2, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 4'b0000, 1'b1, 32'hA2,    2, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 4'b0000, 1'b1, 32'hA3,    1, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 4'b0110, 1'b0, 32'h0,    -1, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 4'b0000, 1'b0, 32'h0,    -1, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 4'b0000, 1'b1, 32'hDEAD, -1, 4'd0, 1'b0, 1'b1, 1'b1};

        // Reset state
        do_reset();
        chk("rst_outstanding", outstanding, 4'd0);
        chk("rst_stall", bus.issue_stall, 1'b0);
        chk("rst_rsp_rdy", bus.rsp_rdy, 1'b1);
        chk("rst_cli_vld", bus.cli_rsp_vld, 4'b0000);
        chk("rst_err_unexp", err_unexp, 1'b0);
        chk("rst_err_onehot", err_onehot, 1'b0);

        // Table: in-order routing, bad grants, response while empty
        for (int r = 0; r < 9; r++) begin
            bus.issue_vld   = vecs[r].iv;
            bus.issue_gnt   = vecs[r].gnt;
            bus.rsp_vld     = vecs[r].rv;
            bus.rsp_data    = vecs[r].data;
            bus.cli_rsp_rdy = '1;
            if (vecs[r].rv && vecs[r].exp_cli >= 0) begin
                expq.push_back('{vecs[r].exp_cli, vecs[r].data});
            end
            @(negedge clk);
            if (vecs[r].rv && vecs[r].exp_cli < 0) begin
                chk($sformatf("v%0d_drop_rsp_rdy", r), bus.rsp_rdy, 1'b1);
                chk($sformatf("v%0d_drop_cli_vld", r), bus.cli_rsp_vld, 4'b0000);
            end
            step();
            chk($sformatf("v%0d_outstanding", r), outstanding, vecs[r].out);
            chk($sformatf("v%0d_stall", r), bus.issue_stall, vecs[r].stall);
            chk($sformatf("v%0d_err_onehot", r), err_onehot, vecs[r].eoh);
            chk($sformatf("v%0d_err_unexp", r), err_unexp, vecs[r].eux);
        end
        idle();
        repeat (3) step();
        chk("err_unexp_sticky", err_unexp, 1'b1);
        chk("err_onehot_sticky", err_onehot, 1'b1);

        // Fill to DEPTH; push while full is ignored, also alongside a pop
        do_reset();
        chk("reset_clears_err_unexp", err_unexp, 1'b0);
        for (int i = 0; i < 8; i++) begin
            issue(4'(1 << (i % 4)));
            if (i == 6) begin
                chk("seven_no_stall", bus.issue_stall, 1'b0);
            end
        end
        chk("full_outstanding", outstanding, 4'd8);
        chk("full_stall", bus.issue_stall, 1'b1);
        issue(4'b0001);
        chk("ninth_outstanding", outstanding, 4'd8);
        chk("ninth_err_onehot", err_onehot, 1'b0);
        bus.issue_vld = 1'b1;
        bus.issue_gnt = 4'b0010;
        bus.rsp_vld   = 1'b1;
        bus.rsp_data  = 32'hE0;
        expq.push_back('{0, 32'hE0});
        step();
        idle();
        chk("full_push_pop_outstanding", outstanding, 4'd7);
        chk("full_push_pop_stall", bus.issue_stall, 1'b0);
        cl_seq = '{1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < 7; i++) begin
            bus.rsp_vld  = 1'b1;
            bus.rsp_data = 32'hE1 + 32'(i);
            expq.push_back('{cl_seq[i], 32'hE1 + 32'(i)});
            step();
        end
        idle();
        repeat (2) step();
        chk("drain_outstanding", outstanding, 4'd0);

`ifndef RR_RSP_ROUTER_SKID_EN
        // Head-of-line blocking on client 2
        do_reset();
        issue(4'b0100);
        issue(4'b0001);
        bus.rsp_vld     = 1'b1;
        bus.rsp_data    = 32'hB0;
        bus.cli_rsp_rdy = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hol_rsp_rdy", bus.rsp_rdy, 1'b0);
            chk("hol_cli_vld", bus.cli_rsp_vld, 4'b0100);
            chk("hol_cli_data", bus.cli_rsp_data, 32'hB0);
            step();
        end
        chk("hol_outstanding", outstanding, 4'd2);
        bus.cli_rsp_rdy = 4'b1111;
        expq.push_back('{2, 32'hB0});
        @(negedge clk);
        chk("hol_release_rdy", bus.rsp_rdy, 1'b1);
        step();
        chk("hol_pop_outstanding", outstanding, 4'd1);
        bus.rsp_data = 32'hB1;
        expq.push_back('{0, 32'hB1});
        @(negedge clk);
        chk("hol_next_cli_vld", bus.cli_rsp_vld, 4'b0001);
        step();
        idle();
        chk("hol_end_outstanding", outstanding, 4'd0);
`else
        // Skid: one-cycle latency and back-to-back throughput
        do_reset();
        issue(4'b0010);
        bus.rsp_vld  = 1'b1;
        bus.rsp_data = 32'hC0;
        expq.push_back('{1, 32'hC0});
        @(negedge clk);
        chk("skid_lat_cycle0", bus.cli_rsp_vld, 4'b0000);
        step();
        idle();
        @(negedge clk);
        chk("skid_lat_cycle1_vld", bus.cli_rsp_vld, 4'b0010);
        chk("skid_lat_cycle1_data", bus.cli_rsp_data, 32'hC0);
        step();
        for (int i = 0; i < 4; i++) begin
            issue(4'(1 << i));
        end
        for (int i = 0; i < 4; i++) begin
            bus.rsp_vld  = 1'b1;
            bus.rsp_data = 32'hD0 + 32'(i);
            expq.push_back('{i, 32'hD0 + 32'(i)});
            @(negedge clk);
            chk("skid_b2b_rsp_rdy", bus.rsp_rdy, 1'b1);
            step();
        end
        idle();
        chk("skid_b2b_outstanding", outstanding, 4'd0);
        repeat (2) step();
`endif

        // Asynchronous reset in the middle of traffic
        do_reset();
        bus.rsp_vld  = 1'b1;
        bus.rsp_data = 32'hDEAD;
        step();
        idle();
        issue(4'b0000);
        for (int i = 0; i < 4; i++) begin
            issue(4'(1 << i));
        end
        chk("mid_outstanding", outstanding, 4'd4);
        chk("mid_err_unexp", err_unexp, 1'b1);
        chk("mid_err_onehot", err_onehot, 1'b1);
        bus.rsp_vld     = 1'b1;
        bus.rsp_data    = 32'h55;
        bus.cli_rsp_rdy = 4'b0000;
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_outstanding", outstanding, 4'd0);
        chk("arst_cli_vld", bus.cli_rsp_vld, 4'b0000);
        chk("arst_rsp_rdy", bus.rsp_rdy, 1'b1);
        chk("arst_stall", bus.issue_stall, 1'b0);
        chk("arst_err_unexp", err_unexp, 1'b0);
        chk("arst_err_onehot", err_onehot, 1'b0);
        idle();
        step();
        rstn = 1'b1;
        step();

        chk("sb_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rr_rsp_router.md
Name: rr_rsp_router

Overview:
Return-path companion to the round-robin request arbiter.
- The arbiter merges NUM_REQ request streams onto one shared resource; this block routes the resource's in-order responses back to the originating client.
- Each accepted grant is recorded as an encoded index in an in-order tag FIFO.
- Each response is steered to the client at the FIFO head, with per-client valid/ready backpressure.
- Sits between the shared resource's response channel and the NUM_REQ client response ports.

Parameters:
NUM_REQ, 4, number of clients; must be ≥ 2 and match the arbiter.
DEPTH, 8, max outstanding grants; must be a power of 2 and ≥ 2.
DATA_W, 32, response payload width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rstn  input  1  asynchronous active-low reset.
issue_vld  input  1  a granted request was accepted by the resource this cycle.
issue_gnt  input  NUM_REQ  one-hot grant vector from the arbiter, sampled when issue_vld=1.
issue_stall  output  1  tag FIFO full; the arbiter stage must not issue.
rsp_vld  input  1  resource response valid.
rsp_data  input  DATA_W  resource response payload.
rsp_rdy  output  1  response accepted.
cli_rsp_vld  output  NUM_REQ  per-client response valid.
cli_rsp_data  output  DATA_W  response payload, shared by all clients.
cli_rsp_rdy  input  NUM_REQ  per-client ready.
outstanding  output  $clog2(DEPTH)+1  current FIFO occupancy.
err_unexp  output  1  sticky: a response arrived with no outstanding grant.
err_onehot  output  1  sticky: issue_vld with a non-one-hot issue_gnt.

Behaviour:
- Reset (async assert, sync deassert by the system): FIFO empty, outstanding=0, err_*=0, issue_stall=0, rsp_rdy=1 (empty-drop path), cli_rsp_vld=0.
- Push: issue_vld & onehot(issue_gnt) & !full → write the binary index of issue_gnt (IDX_W=$clog2(NUM_REQ) bits) at the tail. Visible at the head the next cycle if the FIFO was empty.
- full = (outstanding==DEPTH); issue_stall = full, combinational from registered count.
  - Push while full is ignored, even if a pop happens in the same cycle. The issuer must honour issue_stall; no error is flagged.
- Non-one-hot issue_gnt (including all-zero) with issue_vld=1: no push; err_onehot set the next cycle and held until reset.
- Routing, non-empty, no skid (combinational, 0 latency):
  - cli_rsp_vld[i] = rsp_vld & (head==i)
  - cli_rsp_data = rsp_data
  - rsp_rdy = cli_rsp_rdy[head]
- Pop: rsp_vld & rsp_rdy & !empty → head advances and outstanding decrements.
- Simultaneous push and pop when not full: outstanding unchanged; pointers both advance.
- Empty: rsp_rdy=1 and cli_rsp_vld=0. A response with rsp_vld=1 is dropped and err_unexp is set sticky.
- Pointers are IDX log2(DEPTH) bits and wrap modulo DEPTH. The count is tracked separately, so full/empty are unambiguous.
- A client holding cli_rsp_rdy low stalls all later responses (head-of-line blocking is intended; ordering is strict).
- cli_rsp_vld must not depend combinationally on cli_rsp_rdy.

Optional Feature:
RR_RSP_ROUTER_SKID_EN
- Defined: a 2-entry skid buffer registers the client-side outputs.
  - cli_rsp_vld and cli_rsp_data are flopped, giving 1-cycle latency from rsp_vld to cli_rsp_vld.
  - rsp_rdy is driven only from skid occupancy, breaking the combinational cli_rsp_rdy→rsp_rdy path.
  - Pop occurs on entry into the skid. Routing uses the index captured with the data.
  - Full throughput is sustained (1 response/cycle when the client is ready).
- Undefined: the combinational path exactly as in Behaviour.

Decomposition:
- Shared package rr_arb_pkg:
  - IDX_W derivation helper
  - onehot2bin function
  - is_onehot function
  - both functions reusable by the arbiter
- One sub-module, rr_idx_fifo: DEPTH × IDX_W synchronous FIFO with count, full and empty outputs, and async active-low reset.
- The skid stage is inline logic under the macro.

Test Plan:
- Reset, then issue gnt=0001, 0100, 0010 on consecutive cycles; return 3 responses with all rdy=1 → cli_rsp_vld pulses on clients 0, 2, 1 in order with matching data; outstanding 3→0.
- Issue 8 grants with no responses → issue_stall=1 when outstanding=8. A 9th issue_vld is ignored: outstanding stays 8 and err_onehot stays 0.
- Head is client 2 with cli_rsp_rdy[2]=0 for 5 cycles and rsp_vld=1 → rsp_rdy=0 and data held. Raise rdy → pop in that cycle; the next head is routed.
- FIFO empty, rsp_vld=1 data=0xDEAD → rsp_rdy=1, all cli_rsp_vld=0, err_unexp=1 held until rstn low.
- issue_vld with gnt=0110, then with gnt=0000 → no push, outstanding=0, err_onehot=1.
- FIFO at 4 entries, assert rstn low mid-stream → immediate clear: outstanding=0, cli_rsp_vld=0, errors cleared. Repeat with RR_RSP_ROUTER_SKID_EN: single-response latency = 1 cycle, back-to-back throughput = 1/cycle.
